// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs drained one entry per cycle
// through a round-robin grant into a registered CDB output.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                          clockIn,
  input  logic                          resetIn,
  input  logic                          readyIn,
  input  logic                          flushIn,
  input  logic [NUM_SRC-1:0]            srcValid,
  input  logic [32*NUM_SRC-1:0]         srcVal,
  input  logic [ROB_WIDTH*NUM_SRC-1:0]  srcDest,
  output logic [NUM_SRC-1:0]            srcStall,
  output logic                          cdbFlag,
  output logic [31:0]                   cdbVal,
  output logic [ROB_WIDTH-1:0]          cdbDest,
  output logic [1:0]                    cdbSrc,
  output logic                          overflowErr
);

  localparam int DEPTH   = 1 << FIFO_WIDTH;
  localparam int ENTRY_W = 32 + ROB_WIDTH;
  localparam int CNT_W   = FIFO_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  logic                       enable;
  logic [NUM_SRC-1:0]         nonEmpty;
  logic [NUM_SRC-1:0]         popSel;
  logic [NUM_SRC-1:0]         pushAcc;
  logic [NUM_SRC-1:0]         pushDrop;
  logic [ENTRY_W*NUM_SRC-1:0] headFlat;
  logic [ENTRY_W-1:0]         headSel;
  logic [1:0]                 lastReg;
  logic [1:0]                 winner;
  logic                       anyGrant;

  // Reset and flush both take priority over normal traffic.
  assign enable = resetIn && readyIn && !flushIn;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      logic [ENTRY_W-1:0]    mem [DEPTH];
      logic [FIFO_WIDTH-1:0] wrPtrReg;
      logic [FIFO_WIDTH-1:0] rdPtrReg;
      logic [CNT_W-1:0]      countReg;
      logic                  full;

      assign full          = (countReg == FULL_CNT);
      assign nonEmpty[gi]  = (countReg != '0);
      assign srcStall[gi]  = (countReg >= STALL_CNT);
      assign headFlat[gi*ENTRY_W +: ENTRY_W] = mem[rdPtrReg];
      assign popSel[gi]    = enable && anyGrant && (winner == 2'(gi));
      // A full FIFO still accepts when its head leaves on the same edge.
      assign pushAcc[gi]   = enable && srcValid[gi] && (!full || popSel[gi]);
      assign pushDrop[gi]  = enable && srcValid[gi] && full && !popSel[gi];

      always_ff @(posedge clockIn) begin
        if (pushAcc[gi]) begin
          mem[wrPtrReg] <= {srcVal[32*gi +: 32], srcDest[ROB_WIDTH*gi +: ROB_WIDTH]};
        end
      end

      always_ff @(posedge clockIn) begin
        if (!resetIn || flushIn) begin
          wrPtrReg <= '0;
          rdPtrReg <= '0;
          countReg <= '0;
        end else if (readyIn) begin
          if (pushAcc[gi]) begin
            wrPtrReg <= wrPtrReg + FIFO_WIDTH'(1);
          end
          if (popSel[gi]) begin
            rdPtrReg <= rdPtrReg + FIFO_WIDTH'(1);
          end
          if (pushAcc[gi] && !popSel[gi]) begin
            countReg <= countReg + CNT_W'(1);
          end else if (popSel[gi] && !pushAcc[gi]) begin
            countReg <= countReg - CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // Search starts just after the last winner and wraps once around.
  always_comb begin
    int idx;
    idx      = 0;
    winner   = '0;
    anyGrant = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(lastReg) + 1 + k) % NUM_SRC;
      if (!anyGrant && nonEmpty[idx]) begin
        anyGrant = 1'b1;
        winner   = 2'(idx);
      end
    end
  end

  assign headSel = headFlat[int'(winner)*ENTRY_W +: ENTRY_W];

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      cdbFlag     <= 1'b0;
      cdbVal      <= '0;
      cdbDest     <= '0;
      cdbSrc      <= '0;
      overflowErr <= 1'b0;
      lastReg     <= 2'(NUM_SRC - 1);
    end else if (flushIn) begin
      cdbFlag <= 1'b0;
    end else if (readyIn) begin
      if (anyGrant) begin
        cdbFlag           <= 1'b1;
        {cdbVal, cdbDest} <= headSel;
        cdbSrc            <= winner;
        lastReg           <= winner;
      end else begin
        cdbFlag <= 1'b0;
      end
      if (|pushDrop) begin
        overflowErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the result bus.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        readyIn = 1'b0;
  logic        flushIn = 1'b0;
  logic [2:0]  srcValid = '0;
  logic [95:0] srcVal = '0;
  logic [11:0] srcDest = '0;
  logic [2:0]  srcStall;
  logic        cdbFlag;
  logic [31:0] cdbVal;
  logic [3:0]  cdbDest;
  logic [1:0]  cdbSrc;
  logic        overflowErr;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [35:0] mq [3][$];
  logic        mFlag = 1'b0;
  logic [31:0] mVal = '0;
  logic [3:0]  mDest = '0;
  logic [1:0]  mSrc = '0;
  int          mLast = 2;
  logic        mOvf = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_WIDTH(4), .NUM_SRC(3), .FIFO_WIDTH(2)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
    .srcValid(srcValid), .srcVal(srcVal), .srcDest(srcDest), .srcStall(srcStall),
    .cdbFlag(cdbFlag), .cdbVal(cdbVal), .cdbDest(cdbDest), .cdbSrc(cdbSrc),
    .overflowErr(overflowErr)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic int model_winner();
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (mLast + 1 + k) % 3;
      if (mq[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_stall();
    logic [2:0] s;
    for (int i = 0; i < 3; i++) s[i] = (mq[i].size() >= 3);
    return s;
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, then wait past the edge.
  task automatic tick(input logic rdy, input logic fl, input logic [2:0] v,
                      input logic [95:0] val, input logic [11:0] dst);
    int sz [3];
    int win;
    logic [35:0] e;
    readyIn = rdy; flushIn = fl; srcValid = v; srcVal = val; srcDest = dst;
    if (!resetIn) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mFlag = 1'b0; mVal = '0; mDest = '0; mSrc = '0; mLast = 2; mOvf = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mFlag = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < 3; i++) sz[i] = mq[i].size();
      win = model_winner();
      if (win >= 0) begin
        e = mq[win].pop_front();
        mFlag = 1'b1; mVal = e[35:4]; mDest = e[3:0]; mSrc = 2'(win); mLast = win;
      end else begin
        mFlag = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i]) begin
          if (sz[i] < 4 || win == i) mq[i].push_back({val[32*i +: 32], dst[4*i +: 4]});
          else mOvf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetIn = 1'b0;
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    resetIn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (cdbVal !== 32'h0 || cdbSrc !== 2'd0 || cdbDest !== 4'd0) begin
      fails++; $display("FAIL reset_regs: got val=%h src=%0d dest=%0d expected 0/0/0", cdbVal, cdbSrc, cdbDest);
    end
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== 1'b0 || srcStall !== 3'b000 || overflowErr !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: cycle %0d got flag=%b stall=%b ovf=%b expected 0/000/0", c, cdbFlag, srcStall, overflowErr);
      end
    end
  endtask

  task automatic test_single_push();
    tick(1'b1, 1'b0, 3'b010, {32'h0, 32'h12345678, 32'h0}, {4'h0, 4'h5, 4'h0});
    tests++;
    if (cdbFlag !== 1'b0) begin
      fails++; $display("FAIL single_no_bypass: got flag=%b expected 0", cdbFlag);
    end
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tests++;
    if (cdbFlag !== 1'b1 || cdbVal !== 32'h12345678 || cdbDest !== 4'd5 || cdbSrc !== 2'd1) begin
      fails++;
      $display("FAIL single_grant: got flag=%b val=%h dest=%0d src=%0d expected 1/12345678/5/1", cdbFlag, cdbVal, cdbDest, cdbSrc);
    end
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tests++;
    if (cdbFlag !== 1'b0 || cdbVal !== 32'h12345678) begin
      fails++; $display("FAIL single_after: got flag=%b val=%h expected 0/12345678", cdbFlag, cdbVal);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    tick(1'b1, 1'b0, 3'b111, {32'hA2, 32'hA1, 32'hA0}, 12'h321);
    for (int j = 0; j < 3; j++) begin
      if (j == 2) tick(1'b1, 1'b0, 3'b001, {64'h0, 32'hB0}, 12'h007);
      else        tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== 1'b1 || cdbSrc !== 2'(j) || cdbDest !== 4'(j + 1) || cdbVal !== 32'hA0 + 32'(j)) begin
        fails++;
        $display("FAIL rr_grant%0d: got flag=%b src=%0d dest=%0d val=%h expected 1/%0d/%0d/%h",
                 j, cdbFlag, cdbSrc, cdbDest, cdbVal, j, j + 1, 32'hA0 + 32'(j));
      end
    end
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tests++;
    if (cdbFlag !== 1'b1 || cdbSrc !== 2'd0 || cdbDest !== 4'd7 || cdbVal !== 32'hB0) begin
      fails++; $display("FAIL rr_repush: got flag=%b src=%0d dest=%0d val=%h expected 1/0/7/b0", cdbFlag, cdbSrc, cdbDest, cdbVal);
    end
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tests++;
    if (cdbFlag !== 1'b0) begin
      fails++; $display("FAIL rr_idle: got flag=%b expected 0", cdbFlag);
    end
  endtask

  task automatic test_backpressure();
    int phase;
    int w;
    int s0;
    bit seen;
    logic [2:0] v;
    logic [31:0] seqv;
    phase = 0; seen = 0; seqv = 32'h100;
    do_reset();
    for (int c = 0; c < 80 && phase < 2; c++) begin
      w = model_winner();
      s0 = mq[0].size();
      v = 3'b000;
      v[1] = (mq[1].size() < 3);
      v[2] = (mq[2].size() < 3);
      tests++;
      if (srcStall[0] !== (s0 >= 3)) begin
        fails++; $display("FAIL bp_stall0: count=%0d got stall=%b expected %b", s0, srcStall[0], s0 >= 3);
      end
      seqv = seqv + 1;
      if (phase == 0) begin
        v[0] = 1'b1;
        tick(1'b1, 1'b0, v, {seqv + 32'h2000, seqv + 32'h1000, seqv}, 12'h321);
        if (s0 == 4 && w != 0) begin
          tests++;
          if (overflowErr !== 1'b1) begin
            fails++; $display("FAIL bp_drop: got ovf=%b expected 1", overflowErr);
          end
          phase = 1;
        end else begin
          tests++;
          if (overflowErr !== 1'b0) begin
            fails++; $display("FAIL bp_no_drop: count=%0d got ovf=%b expected 0", s0, overflowErr);
          end
        end
      end else begin
        v[0] = (s0 == 4 && w == 0);
        tick(1'b1, 1'b0, v, {seqv + 32'h2000, seqv + 32'h1000, 32'hACCE97ED}, 12'h321);
        if (v[0]) phase = 2;
      end
    end
    tests++;
    if (phase != 2) begin
      fails++; $display("FAIL bp_sequence: reached phase %0d expected 2", phase);
    end
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== mFlag || cdbVal !== mVal || cdbSrc !== mSrc || cdbDest !== mDest) begin
        fails++;
        $display("FAIL bp_drain: got flag=%b val=%h src=%0d dest=%0d expected %b/%h/%0d/%0d",
                 cdbFlag, cdbVal, cdbSrc, cdbDest, mFlag, mVal, mSrc, mDest);
      end
      if (cdbFlag === 1'b1 && cdbSrc === 2'd0 && cdbVal === 32'hACCE97ED) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL bp_full_pop_push: got seen=0 expected 1");
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++)
      tick(1'b1, 1'b0, 3'b111, {$urandom, $urandom, $urandom}, 12'($urandom));
    tick(1'b0, 1'b1, 3'b111, {$urandom, $urandom, $urandom}, 12'($urandom));
    tests++;
    if (cdbFlag !== 1'b0 || srcStall !== 3'b000 || overflowErr !== 1'b0 || cdbVal !== mVal) begin
      fails++;
      $display("FAIL flush: got flag=%b stall=%b ovf=%b val=%h expected 0/000/0/%h", cdbFlag, srcStall, overflowErr, cdbVal, mVal);
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== 1'b0) begin
        fails++; $display("FAIL flush_empty: cycle %0d got flag=%b expected 0", c, cdbFlag);
      end
    end
    tick(1'b1, 1'b0, 3'b111, {32'hC2, 32'hC1, 32'hC0}, 12'h987);
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== mFlag || cdbSrc !== mSrc || cdbVal !== mVal) begin
        fails++;
        $display("FAIL flush_last_kept: got flag=%b src=%0d val=%h expected %b/%0d/%h", cdbFlag, cdbSrc, cdbVal, mFlag, mSrc, mVal);
      end
    end
  endtask

  task automatic test_stall_gating();
    int expOrder [5] = '{1, 2, 0, 1, 2};
    do_reset();
    tick(1'b1, 1'b0, 3'b111, {32'hD2, 32'hD1, 32'hD0}, 12'h321);
    tick(1'b1, 1'b0, 3'b111, {32'hE2, 32'hE1, 32'hE0}, 12'h654);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, 3'b111, {$urandom, $urandom, $urandom}, 12'($urandom));
      tests++;
      if (cdbFlag !== 1'b1 || cdbVal !== 32'hD0 || cdbSrc !== 2'd0 || cdbDest !== 4'd1 ||
          srcStall !== 3'b000 || overflowErr !== 1'b0) begin
        fails++;
        $display("FAIL gate_hold: cycle %0d got flag=%b val=%h src=%0d dest=%0d stall=%b ovf=%b expected 1/d0/0/1/000/0",
                 c, cdbFlag, cdbVal, cdbSrc, cdbDest, srcStall, overflowErr);
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b0, 3'b000, '0, '0);
      tests++;
      if (cdbFlag !== 1'b1 || cdbSrc !== 2'(expOrder[c]) || cdbVal !== mVal) begin
        fails++;
        $display("FAIL gate_resume%0d: got flag=%b src=%0d val=%h expected 1/%0d/%h", c, cdbFlag, cdbSrc, cdbVal, expOrder[c], mVal);
      end
    end
    tick(1'b1, 1'b0, 3'b000, '0, '0);
    tests++;
    if (cdbFlag !== 1'b0) begin
      fails++; $display("FAIL gate_drained: got flag=%b expected 0", cdbFlag);
    end
  endtask

  task automatic test_random();
    logic rdy;
    logic fl;
    logic [2:0] v;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      if ((c / 100) % 2 == 0) v = 3'($urandom) & 3'($urandom);
      else                    v = 3'($urandom);
      resetIn = ($urandom_range(0, 199) != 0);
      tick(rdy, fl, v, {$urandom, $urandom, $urandom}, 12'($urandom));
      resetIn = 1'b1;
      tests++;
      if (cdbFlag !== mFlag || cdbVal !== mVal || cdbDest !== mDest || cdbSrc !== mSrc ||
          overflowErr !== mOvf || srcStall !== model_stall()) begin
        fails++;
        $display("FAIL random: cycle %0d got flag=%b val=%h dest=%0d src=%0d ovf=%b stall=%b expected %b/%h/%0d/%0d/%b/%b",
                 c, cdbFlag, cdbVal, cdbDest, cdbSrc, overflowErr, srcStall,
                 mFlag, mVal, mDest, mSrc, mOvf, model_stall());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_stall_gating();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) shared by the result producers: the RS/ALU write-back port, the LSB load-result port and one spare port for a future mul/div unit.
- Each source has a small FIFO. A round-robin arbiter grants one entry per cycle to a registered CDB output.
- The CDB output feeds ROB write-back and the operand-forwarding inputs of the RS and LSB.
- A per-source stall output gives producers backpressure.

Parameters:
- ROB_WIDTH, 4, width of the ROB tag carried with each result.
- NUM_SRC, 3, number of requesters (fixed at 3; index 0 = ALU, 1 = LSB, 2 = spare).
- FIFO_WIDTH, 2, log2 of per-source FIFO depth (DEPTH = 4).

Ports:
- clockIn  input  1  clock; all state updates on the rising edge.
- resetIn  input  1  synchronous, active-low reset.
- readyIn  input  1  global enable; when low, no enqueue, dequeue or pointer update.
- flushIn  input  1  mispredict flush; clears all queued results.
- srcValid  input  NUM_SRC  per-source result valid.
- srcVal  input  32*NUM_SRC  per-source result value; source i occupies bits [32i+31:32i].
- srcDest  input  ROB_WIDTH*NUM_SRC  per-source ROB tag, packed the same way as srcVal.
- srcStall  output  NUM_SRC  per-source backpressure; combinational from FIFO count.
- cdbFlag  output  1  CDB valid (registered).
- cdbVal  output  32  CDB value (registered).
- cdbDest  output  ROB_WIDTH  CDB ROB tag (registered).
- cdbSrc  output  2  index of the granted source (registered).
- overflowErr  output  1  sticky error flag: a push was dropped.

Behaviour:
- Reset (resetIn==0 at an edge):
  - all FIFO counts and pointers cleared to 0;
  - cdbFlag, cdbVal, cdbDest, cdbSrc and overflowErr cleared to 0;
  - round-robin last-grant register set to NUM_SRC-1, so source 0 has first priority.
  - Reset overrides flushIn and readyIn. Reset during queued traffic discards everything.
- Flush (resetIn==1, flushIn==1 at an edge), independent of readyIn:
  - all FIFOs emptied and cdbFlag cleared;
  - srcValid in the same cycle is ignored;
  - the last-grant register and overflowErr are kept.
- Enqueue (readyIn==1, no flush):
  - source i pushes {srcVal_i, srcDest_i} when srcValid[i]==1.
  - The push is accepted if count_i < DEPTH, or if count_i == DEPTH and FIFO i is dequeued in the same cycle.
  - Otherwise the push is dropped and overflowErr is set to 1 (sticky until reset).
- srcStall[i] = (count_i >= DEPTH-1). This leaves one slot of headroom, because producers register their output and may issue one more result after seeing stall.
- Arbitration (readyIn==1, no flush):
  - candidates are the non-empty FIFOs, evaluated on pre-edge counts;
  - search order starts at (last+1) mod NUM_SRC and wraps around;
  - the first non-empty FIFO wins.
- Grant effects at the edge:
  - the head of the winning FIFO is popped;
  - cdbFlag<=1; cdbVal, cdbDest and cdbSrc are loaded with the head entry and the winner index;
  - last<=winner.
  - If no FIFO is non-empty: cdbFlag<=0, the other CDB registers hold, last holds.
- Latency:
  - A push accepted at edge E can be granted no earlier than edge E+1. There is no same-cycle bypass from srcValid to the CDB.
  - Minimum latency is 2 edges from valid sampling to cdbFlag visible.
- Throughput: exactly one result per enabled cycle while any FIFO is non-empty.
- Fairness: with all sources continuously non-empty, grants cycle 0,1,2,0,...
- readyIn==0 (no reset, no flush):
  - all state holds, including the CDB registers, so cdbFlag stays at its previous value;
  - pushes are ignored and are not counted as overflow;
  - srcStall still reflects the current counts.
- FIFO pointers wrap modulo DEPTH; count range is 0..DEPTH.
- Ordering: per source, results leave in push order. No ordering is guaranteed across sources.

Test Plan:
- Reset then idle: drive resetIn=0 for 2 cycles, then 1 → cdbFlag=0, srcStall=000, overflowErr=0 for 10 cycles.
- Single push: source 1 pushes val=0x12345678, dest=5 at edge E → at edge E+1 cdbFlag=1, cdbVal=0x12345678, cdbDest=5, cdbSrc=1; at edge E+2 cdbFlag=0.
- Round-robin: all three sources push one entry in the same cycle (dests 1, 2, 3) → grants to sources 0, 1, 2 on three consecutive edges; a new source-0 push afterwards is granted next.
- Backpressure: source 0 pushes 4 consecutive results while sources 1 and 2 are kept busy → srcStall[0]=1 when count reaches 3; a 5th push while count==4 with no pop sets overflowErr=1; a push at count==4 in a cycle where source 0 is popped is accepted.
- Flush: queue 2 entries in each FIFO, assert flushIn with readyIn=0 → next edge cdbFlag=0, all counts 0, srcStall=000; a same-cycle srcValid is not enqueued.
- Stall gating: readyIn=0 for 3 cycles with queued entries → CDB registers and counts frozen; draining resumes in the original round-robin order after readyIn=1.
